// File: rtl/freq_count_bcd.sv
// rtl/freq_count_bcd.sv - edge-count frequency measurement with BCD conversion and load strobe
module freq_count_bcd #(
    parameter int UPDATE_PERIOD = 1200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal,
    output logic [3:0] ten_count,
    output logic [3:0] unit_count,
    output logic       load,
    output logic       overflow
);

    localparam int PW = $clog2(UPDATE_PERIOD);
    localparam logic [PW-1:0] LAST = PW'(UPDATE_PERIOD - 1);

    typedef enum logic [1:0] {COUNT, TENS, LOAD} state_t;

    state_t        state;
    state_t        state_next;
    logic          s1;
    logic          s2;
    logic          sd;
    logic          rise;
    logic [6:0]    edge_count;
    logic [6:0]    edge_count_next;
    logic [PW-1:0] period;
    logic [PW-1:0] period_next;
    logic [3:0]    tens;
    logic [3:0]    tens_next;
    logic [3:0]    ten_next;
    logic [3:0]    unit_next;
    logic          overflow_next;

    assign rise = s2 & ~sd;
    assign load = (state == LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            sd <= 1'b0;
        end else begin
            s1 <= signal;
            s2 <= s1;
            sd <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= COUNT;
            edge_count <= '0;
            period     <= '0;
            tens       <= '0;
            ten_count  <= '0;
            unit_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            edge_count <= edge_count_next;
            period     <= period_next;
            tens       <= tens_next;
            ten_count  <= ten_next;
            unit_count <= unit_next;
            overflow   <= overflow_next;
        end
    end

    // Display registers are written on the TENS->LOAD transition so the new
    // digits appear in the same cycle as the strobe.
    always_comb begin
        state_next      = state;
        edge_count_next = edge_count;
        period_next     = period;
        tens_next       = tens;
        ten_next        = ten_count;
        unit_next       = unit_count;
        overflow_next   = overflow;
        case (state)
            COUNT: begin
                if (rise && (edge_count != 7'd127)) begin
                    edge_count_next = edge_count + 7'd1;
                end
                if (period == LAST) begin
                    period_next = '0;
                    tens_next   = '0;
                    state_next  = TENS;
                end else begin
                    period_next = period + 1'b1;
                end
            end
            TENS: begin
                if (edge_count >= 7'd10) begin
                    if (tens != 4'd9) begin
                        edge_count_next = edge_count - 7'd10;
                        tens_next       = tens + 4'd1;
                    end else begin
                        ten_next      = tens;
                        unit_next     = 4'd9;
                        overflow_next = 1'b1;
                        state_next    = LOAD;
                    end
                end else begin
                    ten_next      = tens;
                    unit_next     = edge_count[3:0];
                    overflow_next = 1'b0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                edge_count_next = '0;
                state_next      = COUNT;
            end
            default: begin
                state_next = COUNT;
            end
        endcase
    end

endmodule

// File: tb/tb_freq_count_bcd.sv
// tb/tb_freq_count_bcd.sv - self-checking bench for freq_count_bcd (two window lengths)
module tb_freq_count_bcd;

    localparam int W_A = 100;
    localparam int W_B = 400;

    typedef struct {
        int c;
        int t;
        int u;
        int o;
    } cap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sig  [2];
    logic [3:0] ten  [2];
    logic [3:0] unit [2];
    logic       load [2];
    logic       ovf  [2];

    int   n_chk = 0;
    int   n_fail = 0;
    int   win [2];
    int   ws [2];
    int   cnt [2];
    int   lc [2];
    int   rt [2];
    int   ru [2];
    int   ro [2];
    int   et [2];
    int   eu [2];
    int   eo [2];
    logic prev [2];
    int   next_c = 0;
    int   pend [2][$];
    cap_t caps [2][$];

    always #5 clk = ~clk;

    freq_count_bcd #(.UPDATE_PERIOD(W_A)) u_a (
        .clk(clk), .reset(reset), .signal(sig[0]),
        .ten_count(ten[0]), .unit_count(unit[0]), .load(load[0]), .overflow(ovf[0])
    );

    freq_count_bcd #(.UPDATE_PERIOD(W_B)) u_b (
        .clk(clk), .reset(reset), .signal(sig[1]),
        .ten_count(ten[1]), .unit_count(unit[1]), .load(load[1]), .overflow(ovf[1])
    );

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(int d);
        ws[d] = 0;
        cnt[d] = 0;
        lc[d] = -1000;
        et[d] = 0;
        eu[d] = 0;
        eo[d] = 0;
        prev[d] = 1'b0;
        pend[d].delete();
    endtask

    // Window model: a rise driven in cycle c shows up as an edge in cycle c+2 and
    // counts only if that cycle lies inside [ws, ws+W-1].
    task automatic step(int d, int c);
        bit e;
        int n;
        bit big;
        e = 1'b0;
        while (pend[d].size() > 0 && pend[d][0] <= c) begin
            if (pend[d][0] == c) e = 1'b1;
            void'(pend[d].pop_front());
        end
        if (e && c >= ws[d] && c < ws[d] + win[d]) cnt[d]++;
        if (c == ws[d] + win[d] - 1) begin
            big = (cnt[d] >= 100);
            n = big ? 9 : cnt[d] / 10;
            rt[d] = big ? 9 : cnt[d] / 10;
            ru[d] = big ? 9 : cnt[d] % 10;
            ro[d] = big ? 1 : 0;
            lc[d] = c + n + 2;
            ws[d] = lc[d] + 1;
            cnt[d] = 0;
        end
        if (c == lc[d]) begin
            et[d] = rt[d];
            eu[d] = ru[d];
            eo[d] = ro[d];
        end
        chk($sformatf("load%0d", d), int'(load[d]), int'(c == lc[d]));
        chk($sformatf("ten%0d", d), int'(ten[d]), et[d]);
        chk($sformatf("unit%0d", d), int'(unit[d]), eu[d]);
        chk($sformatf("ovf%0d", d), int'(ovf[d]), eo[d]);
        if (load[d]) caps[d].push_back('{c, int'(ten[d]), int'(unit[d]), int'(ovf[d])});
        if (sig[d] && !prev[d]) pend[d].push_back(c + 2);
        prev[d] = sig[d];
    endtask

    always @(negedge clk) begin
        step(0, next_c);
        step(1, next_c);
        if (reset) begin
            model_reset(0);
            model_reset(1);
            next_c = 0;
        end else begin
            next_c++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sig[0] = 1'b0;
        sig[1] = 1'b0;
        tick();
        tick();
        chk("rst_ten", int'(ten[0]), 0);
        chk("rst_unit", int'(unit[0]), 0);
        chk("rst_load", int'(load[0]), 0);
        reset = 1'b0;
        caps[0].delete();
        caps[1].delete();
    endtask

    // Drives cycles start..start+total-1; n pulses rising at first+k*step, high for step/2 cycles.
    task automatic run_rises(int d, int start, int total, int first, int stp, int n);
        int rel;
        for (int c = start; c < start + total; c++) begin
            rel = c - first;
            sig[d] = (rel >= 0) && (rel / stp < n) && (rel % stp < stp / 2);
            tick();
        end
    endtask

    task automatic chk_cap(int d, int idx, int c, int t, int u, int o);
        if (caps[d].size() > idx) begin
            chk("cap_cycle", caps[d][idx].c, c);
            chk("cap_ten", caps[d][idx].t, t);
            chk("cap_unit", caps[d][idx].u, u);
            chk("cap_ovf", caps[d][idx].o, o);
        end else begin
            chk("cap_present", caps[d].size(), idx + 1);
        end
    endtask

    initial begin
        win[0] = W_A;
        win[1] = W_B;
        sig[0] = 1'b0;
        sig[1] = 1'b0;
        model_reset(0);
        model_reset(1);

        // Idle input: zero reading one cycle after the window
        do_reset();
        run_rises(0, 0, 110, 0, 4, 0);
        chk("idle_loads", caps[0].size(), 1);
        chk_cap(0, 0, 101, 0, 0, 0);
        chk("idle_b_loads", caps[1].size(), 0);

        // 25 edges
        do_reset();
        run_rises(0, 0, 110, 0, 4, 25);
        chk("e25_loads", caps[0].size(), 1);
        chk_cap(0, 0, 103, 2, 5, 0);

        // Edge on the last COUNT cycle counts; edge in LOAD does not
        do_reset();
        run_rises(0, 0, 97, 10, 10, 7);
        sig[0] = 1'b1; tick();
        sig[0] = 1'b0; tick();
        sig[0] = 1'b1; tick();
        sig[0] = 1'b0; tick();
        run_rises(0, 101, 110, 1000, 2, 0);
        chk("bnd_loads", caps[0].size(), 2);
        chk_cap(0, 0, 101, 0, 8, 0);
        chk_cap(0, 1, 203, 0, 0, 0);

        // Back-to-back 37 then 4, with an extra edge landing in TENS
        do_reset();
        run_rises(0, 0, 99, 0, 2, 37);
        run_rises(0, 99, 2, 99, 2, 1);
        run_rises(0, 101, 120, 110, 10, 4);
        chk("b2b_loads", caps[0].size(), 2);
        chk_cap(0, 0, 104, 3, 7, 0);
        chk_cap(0, 1, 206, 0, 4, 0);

        // Reset during TENS abandons the measurement
        do_reset();
        run_rises(0, 0, 101, 0, 4, 25);
        chk("tens_rst_noload", caps[0].size(), 0);
        do_reset();
        run_rises(0, 0, 110, 0, 6, 12);
        chk("after_rst_loads", caps[0].size(), 1);
        chk_cap(0, 0, 102, 1, 2, 0);

        // Long window: 99, 100, and saturating edge counts
        do_reset();
        run_rises(1, 0, 420, 0, 4, 99);
        chk("e99_loads", caps[1].size(), 1);
        chk_cap(1, 0, 410, 9, 9, 0);

        do_reset();
        run_rises(1, 0, 420, 0, 2, 100);
        chk("e100_loads", caps[1].size(), 1);
        chk_cap(1, 0, 410, 9, 9, 1);

        do_reset();
        run_rises(1, 0, 420, 0, 2, 200);
        chk("esat_loads", caps[1].size(), 1);
        chk_cap(1, 0, 410, 9, 9, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_count_bcd.md
# freq_count_bcd

Measurement core of the frequency counter. It synchronises an asynchronous input signal and counts its rising edges over a fixed window of clock cycles. It converts the count to two BCD digits by repeated subtraction, then presents them with a one-cycle `load` strobe. It sits directly upstream of the seven-segment display driver, whose `load`, `ten_count` and `unit_count` inputs it drives.

## Interface
- `UPDATE_PERIOD`, default 1200: length of the counting window in clk cycles; legal range ≥ 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `signal`  in  1  asynchronous input whose rising edges are counted.
- `ten_count`  out  4  BCD tens digit of the last completed measurement.
- `unit_count`  out  4  BCD units digit of the last completed measurement.
- `load`  out  1  one-cycle strobe: `ten_count`/`unit_count`/`overflow` just updated.
- `overflow`  out  1  last measurement had ≥ 100 edges; digits forced to 9/9.

## Operation
- Input path: two-flop synchroniser `s1`→`s2`, then delay flop `sd`. Internal `edge` = `s2 & ~sd`.
- Edge counter: 7 bits, saturating at 127. Period counter: width `$clog2(UPDATE_PERIOD)`.
- FSM states: COUNT, TENS, LOAD. Reset state is COUNT.
- COUNT:
  - Period counter increments every cycle.
  - Edge counter increments on each `edge` cycle, including the final COUNT cycle.
  - When the period counter equals `UPDATE_PERIOD-1`: clear the period counter, clear the tens accumulator, and go to TENS.
- TENS, one decision per cycle:
  - Edge count ≥ 10 and tens < 9: subtract 10 from the edge count, tens += 1, stay in TENS.
  - Edge count ≥ 10 and tens == 9: set the overflow flag, set units = 9, go to LOAD.
  - Edge count < 10: units = edge count[3:0], overflow flag = 0, go to LOAD.
- LOAD, one cycle:
  - Register `ten_count` = tens, `unit_count` = units, `overflow` = flag.
  - Assert `load`.
  - Clear the edge counter and go to COUNT.
- Dead time: `edge` pulses that occur in TENS or LOAD are discarded.
- `ten_count`, `unit_count` and `overflow` are registered. They hold their value between LOAD cycles.

## Timing
- Reset values: `ten_count`=0, `unit_count`=0, `load`=0, `overflow`=0. Synchroniser flops, counters, tens/units accumulators and overflow flag are all 0; state is COUNT.
- Cycle 0 is the first cycle with `reset` low. COUNT occupies cycles 0 to `UPDATE_PERIOD-1`.
- For N subtractions (0–9), TENS lasts N+1 cycles. `load` is high in exactly cycle `UPDATE_PERIOD+N+1`, and the new digits are visible in that same cycle.
- The next window starts at cycle `UPDATE_PERIOD+N+2`.
- Input latency: a `signal` rise first sampled by `s1` at edge k produces `edge` high in cycle k+2. It is counted only if cycle k+2 is in COUNT.
- Reset mid-window or mid-conversion: the measurement is abandoned with no `load` pulse, all outputs return to reset values, and counting restarts at cycle 0.
- Edge counter saturation: held at 127 and reported as overflow, 9/9.
- `load` never asserts on two consecutive cycles.

## Test plan
- Reset, `signal` held low, `UPDATE_PERIOD`=100 -> outputs 0 during reset. `load` high only at cycle 101 with 0/0 and `overflow`=0.
- `UPDATE_PERIOD`=100, `signal` toggling every 2 clk, giving 25 edges in the window -> `load` at cycle 103, `ten_count`=2, `unit_count`=5, `overflow`=0, one-cycle pulse.
- Exactly 99 edges -> 9/9, `overflow`=0, `load` at W+10. Exactly 100 edges -> 9/9, `overflow`=1. 200 edges (UPDATE_PERIOD ≥ 400) -> counter saturates, 9/9, `overflow`=1.
- Edge boundaries: `edge` landing on the last COUNT cycle is counted (e.g. 7 -> 8). `edge` during TENS or LOAD is not counted in either window.
- `reset` pulsed during TENS -> no `load`, digits stay 0. The next window counts from 0 and reports correctly at the expected cycle.
- Back-to-back windows with 37 then 4 edges -> second `load` shows 3/7 then 0/4. Outputs hold steady between strobes.
